// File: rtl/can_tx_framer_pkg.sv
// can_pkg: shared state encoding, CAN field constants and payload sizing helper.
package can_pkg;
  typedef enum logic [3:0] {
    ST_IDLE, ST_ARB, ST_CTRL, ST_DATA, ST_CRC,
    ST_CRC_DEL, ST_ACK, ST_ACK_DEL, ST_EOF, ST_IFS
  } can_state_e;
  localparam logic [14:0] CRC_POLY = 15'h4599;
  localparam int EOF_LEN = 7;
  localparam int IFS_LEN = 3;
  localparam int STUFF_LEN = 5;
  localparam int ID_STD_W = 11;
  localparam int ID_EXT_W = 29;
  localparam int DLC_W = 4;
  localparam int CRC_W = 15;
  localparam int ARB_STD_LEN = 13;
  localparam int ARB_EXT_LEN = 33;
  localparam int CTRL_LEN = 6;
  function automatic logic [3:0] data_bytes(input logic rtr, input logic [3:0] dlc, input int max_bytes);
    logic [3:0] n;
    n = (dlc > 4'd8) ? 4'd8 : dlc;
    n = (n > 4'(max_bytes)) ? 4'(max_bytes) : n;
    return rtr ? 4'd0 : n;
  endfunction
endpackage

// File: rtl/can_tx_framer_if.sv
// can_tx_framer_if: frame request, bus and status signals of the CAN transmit framer.
interface can_tx_framer_if #(parameter int MAX_BYTES = 8);
  import can_pkg::*;
  logic frame_valid, frame_ready, ide, rtr, rx, tx, busy, done, ack_err;
  logic [ID_EXT_W-1:0] id;
  logic [DLC_W-1:0] dlc;
  logic [8*MAX_BYTES-1:0] data;
  logic [CRC_W-1:0] crc_out;
  modport master (
    output frame_valid, id, ide, rtr, dlc, data, rx,
    input frame_ready, tx, busy, done, ack_err, crc_out
  );
  modport slave (
    input frame_valid, id, ide, rtr, dlc, data, rx,
    output frame_ready, tx, busy, done, ack_err, crc_out
  );
endinterface

// File: rtl/can_tx_framer_crc15.sv
// can_crc15: bit-serial CAN CRC-15 register with synchronous clear and update enable.
module can_crc15
  import can_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_bit,
  output logic [CRC_W-1:0] o_crc
);
  logic [CRC_W-1:0] r_crc;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_crc <= '0;
    else if (i_clr) r_crc <= '0;
    else if (i_en) r_crc <= {r_crc[CRC_W-2:0], 1'b0} ^ ((i_bit ^ r_crc[CRC_W-1]) ? CRC_POLY : '0);
  assign o_crc = r_crc;
endmodule

// File: rtl/can_tx_framer.sv
// can_tx_framer: serialises a CAN 2.0A/B data or remote frame with stuffing, CRC-15 and ACK check.
module can_tx_framer
  import can_pkg::*;
#(
  parameter int MAX_BYTES = 8,
  parameter int BIT_DIV   = 4,
  parameter int EXT_EN    = 1
) (
  input logic clk,
  input logic rst_n,
  can_tx_framer_if.slave bus
);
  localparam int DW = $clog2(BIT_DIV);
  can_state_e r_state, w_nstate;
  logic [5:0] r_idx, w_last, w_nidx;
  logic [DW-1:0] r_div;
  logic [2:0] r_cnt;
  logic r_tx, r_busy, r_done, r_ack_err, r_ide, r_rtr;
  logic [31:0] r_id;
  logic [3:0] r_dlc, r_nbytes;
  logic [8*MAX_BYTES-1:0] r_data;
  logic [63:0] w_data;
  logic [CRC_W-1:0] w_crc;
  logic [15:0] w_crc_x;
  logic w_accept, w_bit_end, w_stuff, w_adv, w_crc_en, w_std_bit, w_ext_bit, w_nbit;
  assign w_data = 64'(r_data);
  assign w_crc_x = {1'b0, w_crc};
  assign w_accept = !r_busy && bus.frame_valid;
  assign w_bit_end = r_state != ST_IDLE && r_div == DW'(BIT_DIV - 1);
  assign w_stuff = r_state inside {ST_ARB, ST_CTRL, ST_DATA, ST_CRC} && r_cnt == 3'(STUFF_LEN);
  assign w_adv = w_bit_end && !w_stuff;
  assign w_crc_en = w_adv && w_nstate inside {ST_ARB, ST_CTRL, ST_DATA};
  assign w_last = r_state == ST_ARB  ? (r_ide ? 6'(ARB_EXT_LEN - 1) : 6'(ARB_STD_LEN - 1)) :
                  r_state == ST_CTRL ? 6'(CTRL_LEN - 1) :
                  r_state == ST_DATA ? 6'({r_nbytes, 3'b000} - 7'd1) :
                  r_state == ST_CRC  ? 6'(CRC_W - 1) :
                  r_state == ST_EOF  ? 6'(EOF_LEN - 1) :
                  r_state == ST_IFS  ? 6'(IFS_LEN - 1) : 6'd0;
  assign w_nidx = r_idx == w_last ? 6'd0 : r_idx + 6'd1;
  assign w_nstate = r_idx != w_last ? r_state :
                    (r_state == ST_CTRL && r_nbytes == 4'd0) ? ST_CRC :
                    r_state == ST_IFS ? ST_IDLE : can_state_e'(r_state + 4'd1);
  // Field bit at the position about to be loaded; index 0 of ARB is SOF.
  assign w_std_bit = w_nidx <= 6'd11 ? r_id[5'(6'd11 - w_nidx)] : r_rtr;
  assign w_ext_bit = w_nidx <= 6'd11 ? r_id[5'(6'd29 - w_nidx)] :
                     w_nidx <= 6'd13 ? 1'b1 :
                     w_nidx <= 6'd31 ? r_id[5'(6'd31 - w_nidx)] : r_rtr;
  assign w_nbit = w_nstate == ST_ARB  ? (w_nidx == 6'd0 ? 1'b0 : r_ide ? w_ext_bit : w_std_bit) :
                  w_nstate == ST_CTRL ? (w_nidx < 6'd2 ? 1'b0 : r_dlc[2'(6'd5 - w_nidx)]) :
                  w_nstate == ST_DATA ? w_data[{w_nidx[5:3], ~w_nidx[2:0]}] :
                  w_nstate == ST_CRC  ? w_crc_x[4'(6'd14 - w_nidx)] : 1'b1;
  can_crc15 u_crc (
    .clk(clk), .rst_n(rst_n), .i_clr(w_accept), .i_en(w_crc_en), .i_bit(w_nbit), .o_crc(w_crc)
  );
  // Stuff bits leave r_idx on the last field bit so the next advance resumes the field.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx <= '0;
      r_div <= '0;
      r_cnt <= '0;
      r_tx <= 1'b1;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_ack_err <= 1'b0;
      r_ide <= 1'b0;
      r_rtr <= 1'b0;
      r_id <= '0;
      r_dlc <= '0;
      r_nbytes <= '0;
      r_data <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (r_done) r_busy <= 1'b0;
        else if (w_accept) begin
          r_state <= ST_ARB;
          r_idx <= '0;
          r_div <= '0;
          r_cnt <= 3'd1;
          r_tx <= 1'b0;
          r_busy <= 1'b1;
          r_ack_err <= 1'b0;
          r_ide <= bus.ide && EXT_EN != 0;
          r_rtr <= bus.rtr;
          r_id <= 32'(bus.id);
          r_dlc <= bus.dlc;
          r_nbytes <= data_bytes(bus.rtr, bus.dlc, MAX_BYTES);
          r_data <= bus.data;
        end
      end else if (!w_bit_end) r_div <= r_div + 1'b1;
      else begin
        r_div <= '0;
        r_tx <= w_stuff ? ~r_tx : w_nbit;
        r_cnt <= (w_stuff || w_nbit != r_tx) ? 3'd1 : r_cnt + 3'd1;
        if (!w_stuff) begin
          r_state <= w_nstate;
          r_idx <= w_nidx;
          r_done <= w_nstate == ST_IDLE;
        end
      end
      if (r_state == ST_ACK && r_div == DW'(BIT_DIV / 2)) r_ack_err <= bus.rx;
    end
  assign bus.frame_ready = !r_busy;
  assign bus.tx = r_tx;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.ack_err = r_ack_err;
  assign bus.crc_out = w_crc;
endmodule

// File: tb/tb_can_tx_framer.sv
// tb_can_tx_framer: randomized frames compared bit-by-bit against a queue-based CAN frame model.
module tb_can_tx_framer;
  localparam int MB = 8;
  localparam int BD = 4;
  logic clk = 1'b0;
  logic rst_n;
  int n_tests = 0;
  int n_fail = 0;
  int done_cnt = 0;
  always #5 clk = ~clk;
  can_tx_framer_if #(.MAX_BYTES(MB)) bus ();
  can_tx_framer #(.MAX_BYTES(MB), .BIT_DIV(BD), .EXT_EN(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always @(posedge clk) if (bus.done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference frame: field list, CRC by polynomial long division, then stuffing and fixed tail.
  task automatic build(input logic [28:0] id, input logic ide, input logic rtr, input logic [3:0] dlc,
                       input logic [63:0] data, output logic [255:0] exp, output int n, output int ns,
                       output logic [14:0] crc);
    bit m[$];
    bit a[$];
    bit s[$];
    int nb;
    int run;
    bit last;
    logic [15:0] g;
    g = 16'hC599;
    m.push_back(0);
    if (ide) begin
      for (int i = 28; i >= 18; i--) m.push_back(id[i]);
      m.push_back(1); m.push_back(1);
      for (int i = 17; i >= 0; i--) m.push_back(id[i]);
    end else
      for (int i = 10; i >= 0; i--) m.push_back(id[i]);
    m.push_back(rtr);
    m.push_back(0); m.push_back(0);
    for (int i = 3; i >= 0; i--) m.push_back(dlc[i]);
    nb = rtr ? 0 : int'(dlc);
    if (nb > 8) nb = 8;
    if (nb > MB) nb = MB;
    for (int b = 0; b < nb; b++)
      for (int i = 7; i >= 0; i--) m.push_back(data[8*b+i]);
    a = m;
    repeat (15) a.push_back(0);
    for (int i = 0; i < m.size(); i++)
      if (a[i]) for (int j = 0; j < 16; j++) a[i+j] ^= g[15-j];
    crc = '0;
    for (int j = 0; j < 15; j++) crc[14-j] = a[m.size()+j];
    for (int i = 14; i >= 0; i--) m.push_back(crc[i]);
    run = 0;
    last = 0;
    foreach (m[i]) begin
      s.push_back(m[i]);
      if (run > 0 && m[i] == last) run++;
      else begin run = 1; last = m[i]; end
      if (run == 5) begin s.push_back(!m[i]); last = !m[i]; run = 1; end
    end
    ns = s.size();
    repeat (13) s.push_back(1);
    n = s.size();
    exp = '0;
    for (int i = 0; i < n; i++) exp[i] = s[i];
  endtask

  task automatic garble();
    bus.id = 29'($urandom);
    bus.ide = 1'($urandom);
    bus.rtr = 1'($urandom);
    bus.dlc = 4'($urandom);
    bus.data = {$urandom, $urandom};
  endtask

  task automatic run_frame(input string nm, input logic [28:0] id, input logic ide, input logic rtr,
                           input logic [3:0] dlc, input logic [63:0] data, input logic rxa);
    logic [255:0] exp, obs;
    logic [14:0] crc;
    int n, ns, hold, bsy, d0;
    build(id, ide, rtr, dlc, data, exp, n, ns, crc);
    obs = '0;
    hold = 0;
    bsy = 0;
    @(negedge clk);
    bus.id = id; bus.ide = ide; bus.rtr = rtr; bus.dlc = dlc; bus.data = data;
    bus.frame_valid = 1'b1;
    check({nm, ".ready"}, bus.frame_ready, 1'b1);
    d0 = done_cnt;
    @(posedge clk);
    #1 bus.frame_valid = 1'b0;
    for (int k = 0; k < n; k++)
      for (int j = 0; j < BD; j++) begin
        @(negedge clk);
        if (j == 0) begin
          obs[k] = bus.tx;
          if (k == 0) check({nm, ".ackclr"}, bus.ack_err, 1'b0);
          garble();
          bus.frame_valid = (k < n - 3) ? 1'($urandom) : 1'b0;
          bus.rx = (k >= ns && k <= ns + 2) ? rxa : 1'($urandom);
        end else if (bus.tx !== obs[k]) hold++;
        if (bus.busy !== 1'b1 || bus.frame_ready !== 1'b0 || bus.done !== 1'b0) bsy++;
      end
    check({nm, ".bits"}, obs, exp);
    check({nm, ".hold"}, hold, 0);
    check({nm, ".busy"}, bsy, 0);
    @(negedge clk);
    check({nm, ".done_rdy"}, {bus.done, bus.frame_ready}, 2'b10);
    @(negedge clk);
    check({nm, ".idle"}, {bus.done, bus.frame_ready, bus.busy, bus.tx}, 4'b0101);
    check({nm, ".ack_err"}, bus.ack_err, rxa);
    check({nm, ".crc"}, bus.crc_out, crc);
    check({nm, ".done_cnt"}, done_cnt - d0, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.frame_valid = 1'b0;
    bus.id = '0; bus.ide = 1'b0; bus.rtr = 1'b0; bus.dlc = '0; bus.data = '0;
    bus.rx = 1'b1;
    repeat (2) @(negedge clk);
    check("reset", {bus.tx, bus.frame_ready, bus.busy, bus.done, bus.ack_err, bus.crc_out},
          {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 15'd0});
    @(negedge clk) rst_n = 1'b1;
    run_frame("zero", 29'h0, 1'b0, 1'b0, 4'd0, 64'h0, 1'b0);
    run_frame("std123", 29'h123, 1'b0, 1'b0, 4'd2, 64'hA55A, 1'b0);
    run_frame("ext9", 29'h1ABCDEF, 1'b1, 1'b0, 4'd9, {$urandom, $urandom}, 1'b0);
    run_frame("rtr4", 29'($urandom), 1'b0, 1'b1, 4'd4, {$urandom, $urandom}, 1'b0);
    run_frame("noack", 29'($urandom), 1'b0, 1'b0, 4'd3, {$urandom, $urandom}, 1'b1);
    run_frame("ackok", 29'($urandom), 1'b1, 1'b0, 4'd1, {$urandom, $urandom}, 1'b0);
    @(negedge clk);
    bus.id = 29'h2AA; bus.ide = 1'b0; bus.rtr = 1'b0; bus.dlc = 4'd8; bus.data = {$urandom, $urandom};
    bus.frame_valid = 1'b1;
    @(posedge clk);
    #1 bus.frame_valid = 1'b0;
    repeat (25 * BD) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("midrst", {bus.tx, bus.frame_ready, bus.busy, bus.done, bus.ack_err, bus.crc_out},
             {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 15'd0});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_frame("postrst", 29'h2AA, 1'b0, 1'b0, 4'd8, {$urandom, $urandom}, 1'b0);
    for (int i = 0; i < 12; i++)
      run_frame($sformatf("rnd%0d", i), 29'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                4'($urandom), {$urandom, $urandom}, 1'($urandom));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/can_tx_framer.md
CAN_TX_FRAMER -- requirements
Module: can_tx_framer

Interface
REQ-001 Parameter MAX_BYTES, default 8, SHALL set the data payload capacity in bytes (1..8).
REQ-002 Parameter BIT_DIV, default 4, SHALL set the clocks per CAN bit (>=2).
REQ-003 Parameter EXT_EN, default 1, SHALL enable 29-bit extended frames; when 0, ide SHALL be ignored and treated as 0.
REQ-004 clk  in  1  single clock; all logic on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 frame_valid  in  1  a frame request is presented.
REQ-007 frame_ready  out  1  framer idle; it accepts on frame_valid && frame_ready.
REQ-008 id  in  29  identifier; ID[10:0] is used for standard frames, ID[28:0] for extended frames.
REQ-009 ide  in  1  1 = extended frame.
REQ-010 rtr  in  1  1 = remote frame (no data field).
REQ-011 dlc  in  4  data length code.
REQ-012 data  in  8*MAX_BYTES  payload; byte k = data[8k+7:8k]; byte 0 is sent first, MSB first.
REQ-013 rx  in  1  bus readback, sampled only in the ACK slot.
REQ-014 tx  out  1  serial bus bit; 1 = recessive.
REQ-015 busy  out  1  a frame is in progress.
REQ-016 done  out  1  one-clock pulse at the end of IFS.
REQ-017 ack_err  out  1  the last frame saw no dominant ACK; held until the next acceptance.
REQ-018 crc_out  out  15  CRC of the last frame; valid from CRC_DEL onward.

Function
REQ-019 All request inputs SHALL be registered on acceptance, and the SOF bit SHALL be driven starting the next clock.
REQ-020 Each bit SHALL be held on tx for exactly BIT_DIV clocks, timed by an internal bit counter.
REQ-021 Standard frame order SHALL be: SOF=0, ID[10:0], RTR, IDE=0, r0=0, DLC[3:0], data, CRC[14:0].
REQ-022 Extended frame order SHALL be: SOF, ID[28:18], SRR=1, IDE=1, ID[17:0], RTR, r1=0, r0=0, DLC, data, CRC.
REQ-023 The number of data bytes SHALL be 0 if rtr=1, otherwise min(dlc, 8, MAX_BYTES); the transmitted DLC field SHALL equal the dlc input unchanged.
REQ-024 The CRC SHALL be CRC-15 with polynomial 15'h4599 and init 0, computed over the unstuffed bits from SOF through the last data bit.
REQ-025 Bit stuffing SHALL apply from SOF through CRC[0]: after 5 consecutive equal bits a complement bit is inserted, and that stuff bit begins the next run count.
REQ-026 After CRC the framer SHALL send, without stuffing: CRC delimiter=1, ACK slot tx=1, ACK delimiter=1, EOF 7x1, IFS 3x1.
REQ-027 In the ACK slot, rx SHALL be sampled at bit-counter midpoint (BIT_DIV/2); if rx=1 there, ack_err SHALL be set.
REQ-028 The FSM states SHALL be IDLE, ARB, CTRL, DATA, CRC, CRC_DEL, ACK, ACK_DEL, EOF, IFS; each field advances on its last bit's final clock.
REQ-029 The framer SHALL skip DATA when the data byte count is 0.
REQ-030 busy SHALL be 1 from acceptance until done; frame_ready SHALL equal !busy; done and frame_ready SHALL NOT assert in the same clock.
REQ-031 frame_valid while busy SHALL be ignored, and no input change SHALL affect a frame in flight.

Reset
REQ-032 On rst=0 the framer SHALL immediately return to IDLE with tx=1, busy=0, frame_ready=1, done=0, ack_err=0, crc_out=0, and all counters cleared, including mid-frame.
REQ-033 After reset release, the first accepted frame SHALL begin with a full SOF bit.

Structure
REQ-034 Package can_pkg SHALL hold the state enum, CRC_POLY=15'h4599, EOF_LEN=7, IFS_LEN=3, STUFF_LEN=5, and the field widths.
REQ-035 Sub-module can_crc15 SHALL implement a bit-serial CRC update with enable and clear.

Verification
REQ-036 Standard frame, id=0x000, rtr=0, dlc=0, BIT_DIV=4 -> tx shows 0x5 zeros, then stuff 1, then zeros; 47 unstuffed bits plus stuff bits; done pulses once.
REQ-037 Standard frame, id=0x123, dlc=2, data=16'hA55A -> decoded bitstream (after destuffing) and crc_out match the bench reference model.
REQ-038 Extended frame, id=0x1ABCDEF, ide=1, dlc=9, MAX_BYTES=8 -> DLC field reads 4'b1001, 8 data bytes are sent, and SRR/IDE both read 1.
REQ-039 RTR frame, dlc=4 -> no data field; CRC directly follows DLC.
REQ-040 Hold rx=1 through the ACK slot -> ack_err=1 after the frame; next frame with rx=0 in the slot -> ack_err clears on acceptance and stays 0.
REQ-041 Assert rst=0 mid-DATA -> tx=1 and frame_ready=1 asynchronously; after release a new frame starts cleanly with SOF.
